station_cntrl: RTL
==================

Name: station_cntrl

Overview:
- Command and station sequencer for the barcode reader.
- Accepts 8-bit commands (go-to-station / stop) from the command receiver.
- Watches ID/ID_vld from the barcode reader, returns clr_cmd_rdy/clr_ID_vld handshakes, and drives the motion enable (go).
- Drives a piezo buzzer while motion is blocked; flags a fault if the destination is not found within a timeout.

Parameters:
- BUZZ_HALF, 12500, clock cycles per half period of the buzzer square wave (2 kHz at 50 MHz).
- TIMEOUT, 2**26, cycles allowed in transit without reaching the destination.
- TO_W, 27, width of the transit timeout counter; must satisfy 2**TO_W > TIMEOUT.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- cmd  in  8  command byte: [7:6] opcode, [5:0] destination station ID.
- cmd_rdy  in  1  cmd valid; stays high until cleared.
- clr_cmd_rdy  out  1  one-cycle acknowledge that consumes cmd.
- ID  in  8  last station ID from the barcode reader.
- ID_vld  in  1  ID valid; stays high until cleared.
- clr_ID_vld  out  1  one-cycle acknowledge that consumes ID.
- OK2Move  in  1  obstacle-free indication (1 = path clear).
- go  out  1  motion enable.
- in_transit  out  1  destination pending.
- arrived  out  1  one-cycle pulse when the destination ID is matched.
- fault  out  1  sticky transit timeout flag.
- buzz  out  1  piezo drive.
- buzz_n  out  1  complement of buzz.

Behaviour:
- Opcodes:
  - 2'b01 GO: set destination to cmd[5:0].
  - 2'b00 STOP.
  - 2'b10 and 2'b11 are ignored, but still acknowledged.
- Reset (rst_n=0 at posedge):
  - state=IDLE, dest=0, timeout count=0, fault=0, buzz=0, buzz count=0.
  - Outputs during/after reset: go=0, in_transit=0, arrived=0, buzz_n=1, clr_cmd_rdy=0, clr_ID_vld=0.
  - Reset mid-transit aborts immediately; no arrived pulse is issued.
- Handshake outputs:
  - clr_cmd_rdy, clr_ID_vld and arrived are combinational Mealy outputs, high in the same cycle the input is consumed.
  - Exactly one cycle per consumed item.
- IDLE state:
  - cmd_rdy with GO: latch dest, clear the timeout count, clear fault, pulse clr_cmd_rdy; next state = TRANSIT.
  - cmd_rdy with any other opcode: pulse clr_cmd_rdy; stay in IDLE.
  - ID_vld: pulse clr_ID_vld and discard the ID.
- TRANSIT state (timeout count increments every cycle):
  - cmd_rdy with GO: reload dest, reset the timeout count, pulse clr_cmd_rdy; stay in TRANSIT.
  - cmd_rdy with STOP: pulse clr_cmd_rdy; next state = IDLE; no arrived pulse.
  - cmd_rdy with 2'b10/2'b11: pulse clr_cmd_rdy only.
  - ID_vld with ID == {2'b00, dest}: pulse clr_ID_vld and arrived; next state = IDLE.
  - ID_vld with a non-matching ID: pulse clr_ID_vld; stay in TRANSIT.
  - cmd_rdy and ID_vld in the same cycle: both are acknowledged that cycle. The command is executed; the ID is discarded without comparison, so no arrived pulse.
  - Timeout count reaches TIMEOUT-1 with no other event: fault<=1; next state = IDLE. A command or ID in that same cycle takes priority and fault is not set.
- Output equations:
  - in_transit = (state==TRANSIT), registered via state.
  - go = in_transit & OK2Move, combinational, with no latency from OK2Move.
- Buzzer:
  - Active when in_transit & ~OK2Move.
  - While active, the buzz count increments; at BUZZ_HALF-1 it wraps to 0 and buzz toggles.
  - While inactive, buzz count and buzz are held at 0.
  - The first toggle occurs BUZZ_HALF cycles after activation.
- Widths: buzz count is $clog2(BUZZ_HALF) bits; timeout count is TO_W bits and saturates (never wraps).

Decomposition:
- Package station_pkg holds:
  - typedef enum logic[1:0] {OP_STOP=2'b00, OP_GO=2'b01} cmd_op_t
  - typedef enum logic {IDLE, TRANSIT} stn_state_t
  - localparam ID_W=6
- One sub-module: piezo_drv, containing the buzz counter and toggle flop. Ports: clk, rst_n, en, buzz, buzz_n; parameter BUZZ_HALF.
- FSM, dest register and timeout counter stay in station_cntrl.

Test Plan:
- Reset, then cmd=8'h45 with cmd_rdy:
  - clr_cmd_rdy is high the same cycle.
  - in_transit=1 and go=1 the next cycle (OK2Move=1).
- In transit to 5:
  - ID=8'h03 with ID_vld: clr_ID_vld pulses; in_transit stays 1.
  - Then ID=8'h05: clr_ID_vld and arrived pulse together; in_transit=0 next cycle.
- In transit, drop OK2Move:
  - go=0 immediately.
  - buzz toggles every BUZZ_HALF cycles (use BUZZ_HALF=4 in the bench) and buzz_n is always ~buzz.
  - Restoring OK2Move returns buzz to 0 the next cycle.
- In transit to 5, same cycle cmd=8'h00 and ID=8'h05:
  - Both clears pulse; arrived stays 0; state goes to IDLE.
- TIMEOUT=20, GO to 9, no IDs:
  - fault=1 and in_transit=0 at cycle 20.
  - A new GO clears fault the next cycle.
- Assert rst_n=0 for one posedge mid-transit with buzz active:
  - All outputs return to reset values the following cycle; no arrived pulse.

Source files
------------

// File: rtl/station_pkg.sv
// Shared types for the station sequencer: command layout, opcodes, FSM states.
package station_pkg;

    localparam int unsigned ID_W  = 6;
    localparam int unsigned CMD_W = 8;

    typedef enum logic [1:0] {
        OP_STOP = 2'b00,
        OP_GO   = 2'b01
    } cmd_op_t;

    typedef enum logic {
        IDLE,
        TRANSIT
    } stn_state_t;

    typedef struct packed {
        logic [1:0]      op;
        logic [ID_W-1:0] dest;
    } cmd_t;

    // Barcode IDs carry two reserved high bits that must be zero to match.
    function automatic logic id_match(input logic [CMD_W-1:0] id, input logic [ID_W-1:0] dest);
        return id == {2'b00, dest};
    endfunction

endpackage

// File: rtl/station_if.sv
// Command / barcode / motion signal bundle between the sequencer and its neighbours.
interface station_if;
    import station_pkg::*;

    cmd_t             cmd;
    logic             cmd_rdy;
    logic             clr_cmd_rdy;
    logic [CMD_W-1:0] ID;
    logic             ID_vld;
    logic             clr_ID_vld;
    logic             OK2Move;
    logic             go;
    logic             in_transit;
    logic             arrived;
    logic             fault;
    logic             buzz;
    logic             buzz_n;

    modport master (
        output cmd, cmd_rdy, ID, ID_vld, OK2Move,
        input  clr_cmd_rdy, clr_ID_vld, go, in_transit, arrived, fault, buzz, buzz_n
    );

    modport slave (
        input  cmd, cmd_rdy, ID, ID_vld, OK2Move,
        output clr_cmd_rdy, clr_ID_vld, go, in_transit, arrived, fault, buzz, buzz_n
    );

endinterface

// File: rtl/station_cntrl_piezo_drv.sv
// Piezo square-wave generator: toggles every BUZZ_HALF enabled cycles, idles low.
module piezo_drv #(
    parameter int unsigned BUZZ_HALF = 12500
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic buzz,
    output logic buzz_n
);

    localparam int unsigned CNT_W = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !en) begin
            cnt    <= '0;
            buzz   <= 1'b0;
            buzz_n <= 1'b1;
        end else if (cnt == CNT_W'(BUZZ_HALF - 1)) begin
            cnt    <= '0;
            buzz   <= ~buzz;
            buzz_n <= buzz;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/station_cntrl.sv
// Station sequencer: accepts go/stop commands, matches barcode IDs against the
// destination, gates motion on OK2Move, buzzes while blocked and times out transits.
module station_cntrl
    import station_pkg::*;
#(
    parameter int unsigned BUZZ_HALF = 12500,
    parameter int unsigned TIMEOUT   = 2**26,
    parameter int unsigned TO_W      = 27
) (
    input  logic      clk,
    input  logic      rst_n,
    station_if.slave  bus
);

    stn_state_t      state, state_nxt;
    logic [ID_W-1:0] dest;
    logic [TO_W-1:0] to_cnt;
    logic            fault_q;
    logic            cmd_go, cmd_stop, id_hit, to_expired;
    logic            ld_dest, set_fault;
    logic            buzz_en;

    assign cmd_go     = bus.cmd_rdy && (bus.cmd.op == OP_GO);
    assign cmd_stop   = bus.cmd_rdy && (bus.cmd.op == OP_STOP);
    assign id_hit     = bus.ID_vld && id_match(bus.ID, dest);
    assign to_expired = to_cnt >= TO_W'(TIMEOUT - 1);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Commands outrank IDs, which outrank the timeout.
    always_comb begin
        state_nxt = state;
        ld_dest   = 1'b0;
        set_fault = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_go) begin
                    ld_dest   = 1'b1;
                    state_nxt = TRANSIT;
                end
            end
            TRANSIT: begin
                if (bus.cmd_rdy) begin
                    if (cmd_go)        ld_dest   = 1'b1;
                    else if (cmd_stop) state_nxt = IDLE;
                end else if (bus.ID_vld) begin
                    if (id_hit) state_nxt = IDLE;
                end else if (to_expired) begin
                    set_fault = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Timeout counter saturates so a long run of non-matching IDs still expires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dest    <= '0;
            to_cnt  <= '0;
            fault_q <= 1'b0;
        end else if (ld_dest) begin
            dest    <= bus.cmd.dest;
            to_cnt  <= '0;
            fault_q <= 1'b0;
        end else begin
            if (state == TRANSIT && to_cnt != '1) to_cnt <= to_cnt + TO_W'(1);
            if (set_fault) fault_q <= 1'b1;
        end
    end

    // Mealy handshakes, suppressed while reset is asserted.
    always_comb begin
        bus.clr_cmd_rdy = 1'b0;
        bus.clr_ID_vld  = 1'b0;
        bus.arrived     = 1'b0;
        bus.go          = 1'b0;
        bus.in_transit  = (state == TRANSIT);
        if (rst_n) begin
            bus.clr_cmd_rdy = bus.cmd_rdy;
            bus.clr_ID_vld  = bus.ID_vld;
            bus.arrived     = (state == TRANSIT) && !bus.cmd_rdy && id_hit;
            bus.go          = (state == TRANSIT) && bus.OK2Move;
        end
    end

    assign bus.fault = fault_q;
    assign buzz_en   = (state == TRANSIT) && !bus.OK2Move;

    piezo_drv #(.BUZZ_HALF(BUZZ_HALF)) u_piezo (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (buzz_en),
        .buzz   (bus.buzz),
        .buzz_n (bus.buzz_n)
    );

endmodule
